mem_access_sequencer: RTL

Sequences the bit-serial data serialiser through a complete memory transaction: a 12-cycle address phase, a misalignment check, an optional read-latency wait, a 32-cycle data phase and, for stores, a write strobe. It shares the single serialiser/memory port between the instruction-fetch unit and the load/store unit with round-robin arbitration. It sits between the core control and the serialiser, and drives the serialiser's bit-position, mode and function inputs.

---
 rtl/mem_access_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Transaction sequencer for the shared bit-serial memory port: address phase, misalignment
// check, optional read-latency wait, data phase and store strobe, with round-robin fetch/LSU arbitration.
module mem_access_sequencer #(
    parameter int ADDR_BITS    = 12,
    parameter int DATA_BITS    = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_req,
    input  logic       ls_req,
    input  logic       ls_write,
    input  logic [2:0] ls_func,
    input  logic       ser_misaligned,
    output logic       grant_fetch,
    output logic       grant_ls,
    output logic [4:0] ser_bit_pos,
    output logic       ser_mode,
    output logic [2:0] ser_func,
    output logic       bit_valid,
    output logic       mem_we,
    output logic       done,
    output logic       fault
);
    typedef enum logic [2:0] {IDLE, ADDR, CHECK, WAIT, DATA, WRITE, DONE} state_t;

    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BITS - 1);
    localparam logic [4:0] DATA_LAST  = 5'(DATA_BITS - 1);
    localparam logic [4:0] CHECK_POS  = 5'(ADDR_BITS);
    localparam logic [2:0] WAIT_LAST  = 3'(READ_LATENCY - 1);
    localparam logic [2:0] FETCH_FUNC = 3'b010;

    state_t     state_q, state_d;
    logic [4:0] pos_q, pos_d;
    logic [2:0] wait_q, wait_d;
    logic [2:0] func_q, func_d;
    logic       write_q, write_d;
    logic       own_ls_q, own_ls_d;
    logic       rr_ls_last_q, rr_ls_last_d;
    logic       grant_fetch_q, grant_fetch_d;
    logic       grant_ls_q, grant_ls_d;
    logic       ser_mode_q, ser_mode_d;
    logic       bit_valid_q, bit_valid_d;
    logic       mem_we_q, mem_we_d;
    logic       done_q, done_d;
    logic       pick_ls;
    logic       busy;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        wait_d       = wait_q;
        func_d       = func_q;
        write_d      = write_q;
        own_ls_d     = own_ls_q;
        rr_ls_last_d = rr_ls_last_q;
        // On a tie the requester that did not win last time gets the port.
        pick_ls      = ls_req && (!fetch_req || !rr_ls_last_q);

        case (state_q)
            IDLE: begin
                if (fetch_req || ls_req) begin
                    state_d      = ADDR;
                    pos_d        = '0;
                    own_ls_d     = pick_ls;
                    rr_ls_last_d = pick_ls;
                    func_d       = pick_ls ? ls_func : FETCH_FUNC;
                    write_d      = pick_ls && ls_write;
                end
            end
            ADDR: begin
                if (pos_q == ADDR_LAST) begin
                    state_d = CHECK;
                    pos_d   = CHECK_POS;
                end else begin
                    pos_d = pos_q + 5'd1;
                end
            end
            CHECK: begin
                pos_d = '0;
                if (ser_misaligned) begin
                    state_d = IDLE;
                end else if (!write_q && READ_LATENCY > 0) begin
                    state_d = WAIT;
                    wait_d  = WAIT_LAST;
                end else begin
                    state_d = DATA;
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) state_d = DATA;
                else                wait_d  = wait_q - 3'd1;
            end
            DATA: begin
                if (pos_q == DATA_LAST) begin
                    state_d = write_q ? WRITE : DONE;
                    pos_d   = '0;
                end else begin
                    pos_d = pos_q + 5'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            pos_d   = '0;
            func_d  = '0;
            write_d = 1'b0;
        end

        // Outputs are decoded from the next state so they register in step with it.
        busy          = (state_d != IDLE);
        grant_fetch_d = busy && !own_ls_d;
        grant_ls_d    = busy && own_ls_d;
        ser_mode_d    = (state_d == ADDR) || (state_d == CHECK);
        bit_valid_d   = (state_d == ADDR) || (state_d == DATA);
        mem_we_d      = (state_d == WRITE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pos_q         <= '0;
            wait_q        <= '0;
            func_q        <= '0;
            write_q       <= 1'b0;
            own_ls_q      <= 1'b0;
            rr_ls_last_q  <= 1'b1;
            grant_fetch_q <= 1'b0;
            grant_ls_q    <= 1'b0;
            ser_mode_q    <= 1'b0;
            bit_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            wait_q        <= wait_d;
            func_q        <= func_d;
            write_q       <= write_d;
            own_ls_q      <= own_ls_d;
            rr_ls_last_q  <= rr_ls_last_d;
            grant_fetch_q <= grant_fetch_d;
            grant_ls_q    <= grant_ls_d;
            ser_mode_q    <= ser_mode_d;
            bit_valid_q   <= bit_valid_d;
            mem_we_q      <= mem_we_d;
            done_q        <= done_d;
        end
    end

    assign grant_fetch = grant_fetch_q;
    assign grant_ls    = grant_ls_q;
    assign ser_bit_pos = pos_q;
    assign ser_mode    = ser_mode_q;
    assign ser_func    = func_q;
    assign bit_valid   = bit_valid_q;
    assign mem_we      = mem_we_q;
    assign done        = done_q;
    // The misalignment flag only becomes valid in the check cycle, so the abort pulse follows it there.
    assign fault       = (state_q == CHECK) && ser_misaligned;
endmodule
